// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential divider.
// The master drives start and operands; the slave returns busy, done and results.
// Operand and result widths follow WIDTH, which must match the divider instance.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Latency WIDTH+1 edges from accept to done (1 edge for divide by zero).
// start is ignored while busy; results hold until the next done.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;       // dividend shift register, fills with quotient bits
    logic [WIDTH-1:0] d_q, d_d;       // latched divisor
    // Partial remainder: always below the divisor, so its top (WIDTH+1'th) bit is
    // constantly zero and is not stored.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;        // {R, next dividend bit}
    logic [WIDTH:0]   trial;          // shifted - divisor, MSB set when negative
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    // One restoring step plus the IDLE/RUN next-state and result-register logic.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        shifted = {r_q, q_q[WIDTH-1]};
        trial   = shifted - {1'b0, d_q};
        q_step  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        // A restore only happens when shifted < D, so shifted fits WIDTH bits then.
        r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end else begin
                        // Divide by zero resolves in one edge without entering RUN.
                        quo_d  = '1;
                        rem_d  = bus.dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and result registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a cycle-level arithmetic model.
// Operands are driven on the falling edge; outputs are compared on every falling edge.
// A few literal expectations pin the model for the documented cases.
module tb_seq_divider;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted division completes exactly W edges after acceptance with
    // dividend/divisor and dividend%divisor; divide by zero completes on the accept edge.
    int               ecnt = 0;
    int               acc_e = 0;
    bit               acc_valid = 1'b0;
    logic [W-1:0]     p_q = '0, p_r = '0, p_dvd = '0, p_dvs = '0;
    logic [W-1:0]     l_dvd = '0, l_dvs = '0;
    logic [W-1:0]     m_q = '0, m_r = '0;
    bit               m_dbz = 1'b0, m_done = 1'b0, m_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit idle;
        if (!rst_n) begin
            acc_valid = 1'b0;
            m_q = '0; m_r = '0; m_dbz = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end else begin
            ecnt++;
            idle   = !(acc_valid && ecnt <= acc_e + W);
            m_done = 1'b0;
            if (acc_valid && ecnt == acc_e + W) begin
                m_q = p_q; m_r = p_r; m_dbz = 1'b0; m_done = 1'b1;
                l_dvd = p_dvd; l_dvs = p_dvs;
                acc_valid = 1'b0;
            end
            if (idle && bus.start) begin
                if (bus.divisor == '0) begin
                    m_q = '1; m_r = bus.dividend; m_dbz = 1'b1; m_done = 1'b1;
                end else begin
                    acc_valid = 1'b1;
                    acc_e = ecnt;
                    p_dvd = bus.dividend;
                    p_dvs = bus.divisor;
                    p_q = bus.dividend / bus.divisor;
                    p_r = bus.dividend % bus.divisor;
                end
            end
            m_busy = acc_valid && (ecnt < acc_e + W);
        end
    end

    // Every-cycle comparison against the model, plus the division invariant on done.
    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("quotient", 32'(bus.quotient), 32'(m_q));
        chk("remainder", 32'(bus.remainder), 32'(m_r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
        if (bus.done && !bus.div_by_zero) begin
            chk("inv_sum", 32'(bus.quotient) * 32'(l_dvs) + 32'(bus.remainder), 32'(l_dvd));
            chk("inv_rem_lt_div", 32'(bus.remainder < l_dvs), 32'd1);
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic launch(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // lat = number of edges from the accept edge to the cycle showing done.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int elat, input string nm);
        int lat;
        launch(dvd, dvs);
        wait_done(lat);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_q"}, 32'(bus.quotient), 32'(eq));
        chk({nm, "_r"}, 32'(bus.remainder), 32'(er));
        chk({nm, "_dbz"}, 32'(bus.div_by_zero), 32'(edz));
    endtask

    initial begin
        int lat;
        logic [W-1:0] dvd, dvs;

        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_q", 32'(bus.quotient), 0);
        chk("rst_r", 32'(bus.remainder), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal and boundary cases.
        launch(8'd200, 8'd7);
        chk("nominal_busy_rise", 32'(bus.busy), 1);
        wait_done(lat);
        chk("nominal_latency", lat, 9);
        chk("nominal_q", 32'(bus.quotient), 28);
        chk("nominal_r", 32'(bus.remainder), 4);
        chk("nominal_dbz", 32'(bus.div_by_zero), 0);
        chk("nominal_busy_fall", 32'(bus.busy), 0);
        @(negedge clk);
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, "b255_1");
        run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, "b5_9");
        run_op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9, "b0_3");
        run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, "b255_255");

        // Divide by zero, then a normal division clears the flag.
        @(negedge clk);
        run_op(8'd77, 8'd0, 8'd255, 8'd77, 1'b1, 1, "dbz");
        chk("dbz_busy", 32'(bus.busy), 0);
        @(negedge clk);
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, "after_dbz");

        // start in the done cycle is accepted; old results hold meanwhile.
        @(negedge clk);
        run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, "b2b_first");
        launch(8'd10, 8'd3);
        chk("hold_q", 32'(bus.quotient), 28);
        chk("hold_r", 32'(bus.remainder), 4);
        wait_done(lat);
        chk("b2b_latency", lat, 9);
        chk("b2b_q", 32'(bus.quotient), 3);
        chk("b2b_r", 32'(bus.remainder), 1);

        // start held high with operands changing during RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!bus.done && lat < 20) begin
            bus.dividend = bus.dividend + 8'd3;
            bus.divisor = bus.divisor + 8'd1;
            @(negedge clk);
            lat++;
        end
        chk("held_start_latency", lat, 9);
        chk("held_start_q", 32'(bus.quotient), 14);
        chk("held_start_r", 32'(bus.remainder), 2);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        chk("held_second_latency", lat, 9);
        chk("held_second_q", 32'(bus.quotient), 8);
        chk("held_second_r", 32'(bus.remainder), 4);

        // Reset during step 4 of 100/3.
        @(negedge clk);
        launch(8'd100, 8'd3);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_q", 32'(bus.quotient), 0);
        chk("midrst_r", 32'(bus.remainder), 0);
        chk("midrst_dbz", 32'(bus.div_by_zero), 0);
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 9, "post_rst");

        // Random operands, including zero divisors and back-to-back starts.
        for (int i = 0; i < 3000; i++) begin
            dvd = W'($urandom);
            dvs = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if (dvs == '0)
                run_op(dvd, dvs, '1, dvd, 1'b1, 1, "rand_dbz");
            else
                run_op(dvd, dvs, dvd / dvs, dvd % dvs, 1'b0, 9, "rand");
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
